// File: rtl/hazard_tracker_pkg.sv
// ============================================================================
//  Module : hazard_tracker_pkg
//  Brief  : Shared widths, forward-select encodings and slot record type
//  Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_tracker_pkg;

    localparam int TW = 2;

    // D-stage forward selects
    localparam logic [1:0] FWD_RF   = 2'd0;
    localparam logic [1:0] FWD_E    = 2'd1;
    localparam logic [1:0] FWD_M    = 2'd2;
    localparam logic [1:0] FWD_W    = 2'd3;

    // E-stage forward selects
    localparam logic [1:0] FWD_EREG = 2'd0;
    localparam logic [1:0] FWD_E_M  = 2'd1;
    localparam logic [1:0] FWD_E_W  = 2'd2;

    typedef struct packed {
        logic          valid;
        logic          wr;
        logic [4:0]    a3;
        logic [TW-1:0] tnew;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_match.sv
// ============================================================================
//  Module : hazard_match
//  Brief  : Per-source hazard detect: newest-match forward select + stall term
//  Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_match
    import hazard_tracker_pkg::*;
#(
    parameter logic [1:0] CODE0    = FWD_E,
    parameter logic [1:0] CODE1    = FWD_M,
    parameter logic [1:0] CODE2    = FWD_W,
    parameter bit         STALL_EN = 1'b1
) (
    input  logic [4:0]    i_src,
    input  logic          i_use,
    input  logic [TW-1:0] i_tuse,
    input  slot_t         i_slot0,
    input  slot_t         i_slot1,
    input  slot_t         i_slot2,
    output logic [1:0]    o_sel,
    output logic          o_stall
);

    function automatic logic hit(input slot_t s, input logic [4:0] src, input logic use_f);
        return use_f & s.valid & s.wr & (s.a3 != 5'd0) & (s.a3 == src);
    endfunction

    logic w_hit0;
    logic w_hit1;
    logic w_hit2;

    assign w_hit0 = hit(i_slot0, i_src, i_use);
    assign w_hit1 = hit(i_slot1, i_src, i_use);
    assign w_hit2 = hit(i_slot2, i_src, i_use);

    // Only the newest producer counts; an older ready copy would be stale.
    always_comb begin
        o_sel = 2'd0;
        if (w_hit0) begin
            o_sel = (i_slot0.tnew == '0) ? CODE0 : 2'd0;
        end else if (w_hit1) begin
            o_sel = (i_slot1.tnew == '0) ? CODE1 : 2'd0;
        end else if (w_hit2) begin
            o_sel = (i_slot2.tnew == '0) ? CODE2 : 2'd0;
        end
    end

    assign o_stall = STALL_EN & ((w_hit0 & (i_slot0.tnew > i_tuse)) |
                                 (w_hit1 & (i_slot1.tnew > i_tuse)));

endmodule

`default_nettype wire

// File: rtl/hazard_tracker.sv
// ============================================================================
//  Module : hazard_tracker
//  Brief  : E/M/W destination tracker producing stall and forward selects
//  Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_tracker
    import hazard_tracker_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    rs_D,
    input  logic [4:0]    rt_D,
    input  logic          rs_use_D,
    input  logic          rt_use_D,
    input  logic [TW-1:0] tuse_rs_D,
    input  logic [TW-1:0] tuse_rt_D,
    input  logic [4:0]    a3_D,
    input  logic          wr_D,
    input  logic [TW-1:0] tnew_D,
    input  logic          md_inst_D,
    input  logic          md_busy,
    input  logic          flush,
    output logic          stall,
    output logic [1:0]    fwd_rs_D,
    output logic [1:0]    fwd_rt_D,
    output logic [1:0]    fwd_rs_E,
    output logic [1:0]    fwd_rt_E
);

    slot_t      r_e;
    slot_t      r_m;
    slot_t      r_w;
    logic [4:0] r_e_rs;
    logic [4:0] r_e_rt;

    slot_t      w_e_load;
    slot_t      w_m_adv;
    slot_t      w_w_adv;
    logic       w_rs_d_stall;
    logic       w_rt_d_stall;
    logic       w_rs_e_stall;
    logic       w_rt_e_stall;

    always_comb begin
        w_e_load       = SLOT_EMPTY;
        w_e_load.valid = 1'b1;
        w_e_load.wr    = wr_D;
        w_e_load.a3    = a3_D;
        w_e_load.tnew  = tnew_D;

        w_m_adv        = r_e;
        w_m_adv.tnew   = tnew_dec(r_e.tnew);

        w_w_adv        = r_m;
        w_w_adv.tnew   = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_e    <= SLOT_EMPTY;
            r_m    <= SLOT_EMPTY;
            r_w    <= SLOT_EMPTY;
            r_e_rs <= 5'd0;
            r_e_rt <= 5'd0;
        end else begin
            r_w <= w_w_adv;
            if (flush) begin
                r_e    <= SLOT_EMPTY;
                r_m    <= SLOT_EMPTY;
                r_e_rs <= 5'd0;
                r_e_rt <= 5'd0;
            end else if (stall) begin
                r_e    <= SLOT_EMPTY;
                r_m    <= w_m_adv;
                r_e_rs <= 5'd0;
                r_e_rt <= 5'd0;
            end else begin
                r_e    <= w_e_load;
                r_m    <= w_m_adv;
                r_e_rs <= rs_D;
                r_e_rt <= rt_D;
            end
        end
    end

    hazard_match #(
        .CODE0(FWD_E), .CODE1(FWD_M), .CODE2(FWD_W), .STALL_EN(1'b1)
    ) u_rs_d (
        .i_src(rs_D), .i_use(rs_use_D), .i_tuse(tuse_rs_D),
        .i_slot0(r_e), .i_slot1(r_m), .i_slot2(r_w),
        .o_sel(fwd_rs_D), .o_stall(w_rs_d_stall)
    );

    hazard_match #(
        .CODE0(FWD_E), .CODE1(FWD_M), .CODE2(FWD_W), .STALL_EN(1'b1)
    ) u_rt_d (
        .i_src(rt_D), .i_use(rt_use_D), .i_tuse(tuse_rt_D),
        .i_slot0(r_e), .i_slot1(r_m), .i_slot2(r_w),
        .o_sel(fwd_rt_D), .o_stall(w_rt_d_stall)
    );

    // E-stage sources only look downstream (M, W); their stall terms are tied off.
    hazard_match #(
        .CODE0(FWD_E_M), .CODE1(FWD_E_W), .CODE2(FWD_EREG), .STALL_EN(1'b0)
    ) u_rs_e (
        .i_src(r_e_rs), .i_use(r_e.valid), .i_tuse('0),
        .i_slot0(r_m), .i_slot1(r_w), .i_slot2(SLOT_EMPTY),
        .o_sel(fwd_rs_E), .o_stall(w_rs_e_stall)
    );

    hazard_match #(
        .CODE0(FWD_E_M), .CODE1(FWD_E_W), .CODE2(FWD_EREG), .STALL_EN(1'b0)
    ) u_rt_e (
        .i_src(r_e_rt), .i_use(r_e.valid), .i_tuse('0),
        .i_slot0(r_m), .i_slot1(r_w), .i_slot2(SLOT_EMPTY),
        .o_sel(fwd_rt_E), .o_stall(w_rt_e_stall)
    );

    assign stall = w_rs_d_stall | w_rt_d_stall | w_rs_e_stall | w_rt_e_stall |
                   (md_inst_D & md_busy);

endmodule

`default_nettype wire

// File: doc/hazard_tracker.md
HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: the single rising-edge clock.
REQ-002 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The module SHALL have port rs_D / rt_D, input, 5 bits each: D-stage source register numbers.
REQ-004 The module SHALL have port rs_use_D / rt_use_D, input, 1 bit each: the D instruction reads that source.
REQ-005 The module SHALL have port tuse_rs_D / tuse_rt_D, input, 2 bits each: cycles until the source is consumed (0 = D-stage, 1 = E-stage).
REQ-006 The module SHALL have port a3_D, input, 5 bits: D-stage destination register.
REQ-007 The module SHALL have port wr_D, input, 1 bit: the D instruction writes a3_D.
REQ-008 The module SHALL have port tnew_D, input, 2 bits: cycles after entering E until the result exists (0 = jal/jalr, 1 = ALU/mfc0/mfhi, 2 = loads).
REQ-009 The module SHALL have port md_inst_D, input, 1 bit: the D instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 The module SHALL have port md_busy, input, 1 bit: the multiply/divide unit is busy or starting.
REQ-011 The module SHALL have port flush, input, 1 bit: exception/eret flush request.
REQ-012 The module SHALL have port stall, output, 1 bit: hold PC and the F/D register, and bubble the D/E register.
REQ-013 The module SHALL have ports fwd_rs_D / fwd_rt_D, output, 2 bits each, with encoding 0 = RF, 1 = E, 2 = M, 3 = W.
REQ-014 The module SHALL have ports fwd_rs_E / fwd_rt_E, output, 2 bits each, with encoding 0 = pipeline register, 1 = M, 2 = W.

Function
REQ-015 The module SHALL keep three stage slots, E, M and W; each slot holds valid, wr, a3[4:0] and tnew[1:0], and the E slot additionally holds rs and rt.
REQ-016 On each clock edge with no stall and no flush, the D fields SHALL load into E (valid = 1), E SHALL move to M and M SHALL move to W.
REQ-017 On each move, tnew SHALL decrement and saturate at 0; W tnew SHALL always be 0.
REQ-018 Under stall with no flush, the E slot SHALL load a bubble (valid = 0) while M and W advance normally.
REQ-019 Flush SHALL win over stall: the E and M slots load bubbles and the W slot receives the old M.
REQ-020 A slot SHALL match source s only when it has valid & wr & a3 != 0 & a3 == s & use_s.
REQ-021 stall SHALL be 1 when the E or M slot matches rs_D with tnew > tuse_rs_D, when the same holds for rt_D, or when md_inst_D & md_busy.
REQ-022 stall SHALL be combinational from the current slots and the D inputs.
REQ-023 The D-stage forward select SHALL consider only the newest matching slot (E, then M, then W) and take that slot's code if its tnew == 0, else 0.
REQ-024 The D-stage forward select SHALL be 0 when no slot matches.
REQ-025 The E-stage forward select SHALL look at the newest match of E.rs or E.rt in M, then W, with tnew == 0, and SHALL be 0 otherwise.
REQ-026 Register 0 SHALL never stall and SHALL never forward.
REQ-027 When the E slot is invalid, fwd_rs_E and fwd_rt_E SHALL be 0.

Reset
REQ-028 Asserting reset (low) SHALL clear every slot's valid, wr, a3, tnew, rs and rt to 0 immediately, regardless of clk.
REQ-029 While reset is held, stall and all fwd outputs SHALL be 0, given md_busy = 0.
REQ-030 Reset deasserting mid-sequence SHALL start from an empty pipeline, with no stale hazards.

Structure
REQ-031 The shared package SHALL hold the tnew/tuse width, the forward-select encodings (FWD_RF, FWD_E, FWD_M, FWD_W, FWD_EREG) and the slot record typedef.
REQ-032 The design SHALL have one sub-module, hazard_match, instantiated four times (rs_D, rt_D, rs_E, rt_E); it takes a source number, a use flag and the slots and returns its select and stall terms.

Verification
REQ-033 Sequence lw $8 (tnew 2), then addu using $8 with tuse 1 -> stall = 1 for one cycle, then addu in E with fwd_rs_E = 2 (W).
REQ-034 Sequence addu $9 (tnew 1), then beq using $9 with tuse 0 -> stall for 1 cycle, then fwd_rs_D = 2 (M).
REQ-035 Sequence jal (a3 = 31, tnew 0), then jr $31 -> no stall and fwd_rs_D = 1 (E).
REQ-036 Sequence ori $0, then addu reading $0 -> stall = 0 and every fwd = 0.
REQ-037 Case lw $8 in E together with a flush while a dependent instruction sits in D -> next cycle E and M invalid, stall = 0; reset pulsed low mid-stall -> outputs 0 at once.
REQ-038 Case md_busy = 1 with mflo in D -> stall = 1 until md_busy falls.
